// File: rtl/aska_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aska_spi_pkg : frame geometry, FSM state encoding, helper functions  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package aska_spi_pkg;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 32;
    localparam int FRAME_BITS   = 40;
    localparam int BYTE_BITS    = 8;
    localparam int HALF_PERIODS = 2 * FRAME_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aska_spi_ser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aska_spi_ser : 40-bit frame shifter with half-bit timer (mode 0)     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module aska_spi_ser
    import aska_spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int CNT_W             = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  run,
    input  logic                  stop,
    input  logic                  clr,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  last_edge
);

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [6:0]       c_hp_last   = 7'(HALF_PERIODS - 1);

    logic [FRAME_BITS-1:0] r_sh;
    logic [CNT_W-1:0]      r_tmr;
    logic [6:0]            r_hp;
    logic                  r_clk;
    logic                  w_tick;
    logic                  w_byte_end;

    assign w_tick     = run && (r_tmr == c_half_last);
    // 16 half periods per byte: half period 16k-1 ends with a byte's last falling edge
    assign w_byte_end = (r_hp[3:0] == 4'hF);
    assign last_edge  = w_tick && r_hp[0] && ((r_hp == c_hp_last) || (stop && w_byte_end));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sh  <= '0;
            r_tmr <= '0;
            r_hp  <= '0;
            r_clk <= 1'b0;
        end else if (load) begin
            r_sh  <= frame;
            r_tmr <= '0;
            r_hp  <= '0;
            r_clk <= 1'b0;
        end else if (clr) begin
            r_sh <= '0;
        end else if (run) begin
            if (w_tick) begin
                r_tmr <= '0;
                r_clk <= ~r_clk;
                if (!last_edge) begin
                    r_hp <= r_hp + 7'd1;
                    if (r_hp[0]) begin
                        r_sh <= {r_sh[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end else begin
                r_tmr <= r_tmr + CNT_W'(1);
            end
        end
    end

    assign spi_clk  = r_clk;
    assign spi_mosi = r_sh[FRAME_BITS-1];

endmodule
`default_nettype wire

// File: rtl/aska_spi_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aska_spi_sched : two-requester round-robin SPI write master          |
// | Optional abort : define ASKA_SPI_SCHED_ABORT_EN                      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module aska_spi_sched
    import aska_spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int CS_SETUP_CLKS     = 4,
    parameter int CS_HOLD_CLKS      = 4,
    parameter int CS_IDLE_CLKS      = 20
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef ASKA_SPI_SCHED_ABORT_EN
    input  logic              abort,
    output logic              done_err,
`endif
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic              SPI_CS,
    output logic              SPI_Clk,
    output logic              SPI_MOSI
);

    localparam int c_max_dly = max_int(max_int(CLKS_PER_HALF_BIT, CS_SETUP_CLKS),
                                       max_int(CS_HOLD_CLKS, CS_IDLE_CLKS));
    localparam int c_cnt_w   = $clog2(c_max_dly);

    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(CS_SETUP_CLKS - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD_CLKS - 1);
    localparam logic [c_cnt_w-1:0] c_idle_last  = c_cnt_w'(CS_IDLE_CLKS - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_prio;
    logic                 r_id;
    logic                 r_cs;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_done_id;
    logic                 r_rdy0;
    logic                 r_rdy1;

    logic                  w_any;
    logic                  w_sel;
    logic                  w_grant;
    logic                  w_last;
    logic                  w_hold_end;
    logic                  w_stop;
    logic [FRAME_BITS-1:0] w_frame;

    // r_prio names the requester that wins when both are valid
    assign w_any      = req0_valid || req1_valid;
    assign w_sel      = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign w_grant    = (r_state == IDLE) && w_any;
    assign w_frame    = w_sel ? {req1_addr, req1_data} : {req0_addr, req0_data};
    assign w_hold_end = (r_state == HOLD) && (r_cnt == c_hold_last);

    aska_spi_ser #(
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
        .CNT_W             (c_cnt_w)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .load      (w_grant),
        .frame     (w_frame),
        .run       (r_state == SHIFT),
        .stop      (w_stop),
        .clr       (w_hold_end),
        .spi_clk   (SPI_Clk),
        .spi_mosi  (SPI_MOSI),
        .last_edge (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_prio    <= 1'b0;
            r_id      <= 1'b0;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_rdy0    <= 1'b0;
            r_rdy1    <= 1'b0;
        end else begin
            r_rdy0 <= 1'b0;
            r_rdy1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_rdy0  <= ~w_sel;
                        r_rdy1  <= w_sel;
                        r_id    <= w_sel;
                        r_prio  <= ~w_sel;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == c_setup_last) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_hold_end) begin
                        r_cnt     <= '0;
                        r_cs      <= 1'b1;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_state   <= GAP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == c_idle_last) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ASKA_SPI_SCHED_ABORT_EN
    logic r_abort;
    logic r_done_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_abort    <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_abort <= 1'b0;
            end else if (abort && ((r_state == SETUP) || (r_state == SHIFT))) begin
                r_abort <= 1'b1;
            end
            r_done_err <= w_hold_end && r_abort;
        end
    end

    assign w_stop   = r_abort;
    assign done_err = r_done_err;
`else
    assign w_stop = 1'b0;
`endif

    assign req0_ready = r_rdy0;
    assign req1_ready = r_rdy1;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign SPI_CS     = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_aska_spi_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aska_spi_sched : directed self-checking bench for aska_spi_sched  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_aska_spi_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, busy, done, done_id;
    logic        SPI_CS, SPI_Clk, SPI_MOSI;
`ifdef ASKA_SPI_SCHED_ABORT_EN
    logic        abort = 1'b0, done_err, abort2 = 1'b0, done_err2;
`endif

    logic        d2_req0_valid = 1'b0, d2_req1_valid = 1'b0;
    logic [7:0]  d2_req0_addr = '0, d2_req1_addr = '0;
    logic [31:0] d2_req0_data = '0, d2_req1_data = '0;
    logic        d2_req0_ready, d2_req1_ready, busy2, done2, done_id2;
    logic        cs2, sclk2, mosi2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aska_spi_sched u_dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef ASKA_SPI_SCHED_ABORT_EN
        .abort      (abort),
        .done_err   (done_err),
`endif
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .SPI_CS     (SPI_CS),
        .SPI_Clk    (SPI_Clk),
        .SPI_MOSI   (SPI_MOSI)
    );

    aska_spi_sched #(
        .CLKS_PER_HALF_BIT (2),
        .CS_SETUP_CLKS     (1)
    ) u_dut2 (
        .clk        (clk),
        .resetn     (resetn),
`ifdef ASKA_SPI_SCHED_ABORT_EN
        .abort      (abort2),
        .done_err   (done_err2),
`endif
        .req0_valid (d2_req0_valid),
        .req0_addr  (d2_req0_addr),
        .req0_data  (d2_req0_data),
        .req0_ready (d2_req0_ready),
        .req1_valid (d2_req1_valid),
        .req1_addr  (d2_req1_addr),
        .req1_data  (d2_req1_data),
        .req1_ready (d2_req1_ready),
        .busy       (busy2),
        .done       (done2),
        .done_id    (done_id2),
        .SPI_CS     (cs2),
        .SPI_Clk    (sclk2),
        .SPI_MOSI   (mosi2)
    );

    // Slave-side view of u_dut: per-frame capture, CS length, gap, edge count
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    int          cs_len = 0, gap_len = 0, cur_edges = 0, n_frames = 0;
    int          n_rdy0 = 0, n_rdy1 = 0, n_done = 0;
    logic [39:0] cur_cap = '0;
    logic [39:0] fr_cap [0:15];
    int          fr_len [0:15];
    int          fr_edges [0:15];
    int          fr_gap [0:15];
    logic        fr_done [0:15];
    logic        fr_id [0:15];
    logic        fr_err [0:15];

    always @(negedge clk) begin
        prev_cs   <= SPI_CS;
        prev_sclk <= SPI_Clk;
        if (req0_ready) n_rdy0 <= n_rdy0 + 1;
        if (req1_ready) n_rdy1 <= n_rdy1 + 1;
        if (done)       n_done <= n_done + 1;
        if (!SPI_CS) begin
            if (prev_cs) begin
                cs_len    <= 1;
                cur_edges <= 0;
                cur_cap   <= '0;
                if (n_frames < 16) fr_gap[n_frames] <= gap_len;
            end else begin
                cs_len <= cs_len + 1;
                if (SPI_Clk && !prev_sclk) begin
                    cur_edges <= cur_edges + 1;
                    cur_cap   <= {cur_cap[38:0], SPI_MOSI};
                end
            end
        end else begin
            if (!prev_cs) begin
                if (n_frames < 16) begin
                    fr_cap[n_frames]   <= cur_cap;
                    fr_len[n_frames]   <= cs_len;
                    fr_edges[n_frames] <= cur_edges;
                    fr_done[n_frames]  <= done;
                    fr_id[n_frames]    <= done_id;
`ifdef ASKA_SPI_SCHED_ABORT_EN
                    fr_err[n_frames]   <= done_err;
`else
                    fr_err[n_frames]   <= 1'b0;
`endif
                end
                n_frames <= n_frames + 1;
                gap_len  <= 1;
            end else begin
                gap_len <= gap_len + 1;
            end
        end
    end

    logic        prev_cs2 = 1'b1, prev_sclk2 = 1'b0;
    int          len2 = 0, edges2 = 0, n2 = 0, run_len2 = 0, run_edges2 = 0;
    logic [39:0] cap2 = '0, run_cap2 = '0;
    logic        fdone2 = 1'b0, fid2 = 1'b0;

    always @(negedge clk) begin
        prev_cs2   <= cs2;
        prev_sclk2 <= sclk2;
        if (!cs2) begin
            if (prev_cs2) begin
                run_len2   <= 1;
                run_edges2 <= 0;
                run_cap2   <= '0;
            end else begin
                run_len2 <= run_len2 + 1;
                if (sclk2 && !prev_sclk2) begin
                    run_edges2 <= run_edges2 + 1;
                    run_cap2   <= {run_cap2[38:0], mosi2};
                end
            end
        end else if (!prev_cs2) begin
            len2   <= run_len2;
            edges2 <= run_edges2;
            cap2   <= run_cap2;
            fdone2 <= done2;
            fid2   <= done_id2;
            n2     <= n2 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit which, input string tag);
        int k = 0;
        while (((which == 1'b0) ? !req0_ready : !req1_ready) && k < 1000) begin
            tick();
            k++;
        end
        check(tag, 64'((which == 1'b0) ? req0_ready : req1_ready), 64'd1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int k = 0;
        while (n_frames < target && k < 3000) begin
            tick();
            k++;
        end
        check(tag, 64'(n_frames), 64'(target));
    endtask

    task automatic wait_edges(input int target, input string tag);
        int k = 0;
        while (cur_edges < target && k < 1000) begin
            tick();
            k++;
        end
        check(tag, 64'(cur_edges), 64'(target));
    endtask

    initial begin
        int snap;
        int k;

        // Reset values
        repeat (3) tick();
        check("rst_cs",    64'(SPI_CS),     64'd1);
        check("rst_clk",   64'(SPI_Clk),    64'd0);
        check("rst_mosi",  64'(SPI_MOSI),   64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        check("rst_id",    64'(done_id),    64'd0);
        check("rst_rdy0",  64'(req0_ready), 64'd0);
        check("rst_rdy1",  64'(req1_ready), 64'd0);

        // Simultaneous pair from reset: requester 0 first
        req0_addr = 8'h01; req0_data = 32'h3377EEFF; req0_valid = 1'b1;
        req1_addr = 8'h03; req1_data = 32'h554466AA; req1_valid = 1'b1;
        tick();
        resetn = 1'b1;
        wait_ready(1'b0, "pair1_rdy0");
        check("pair1_no_rdy1", 64'(n_rdy1), 64'd0);
        req0_valid = 1'b0;
        wait_ready(1'b1, "pair1_rdy1");
        req1_valid = 1'b0;
        wait_frames(2, "pair1_frames");
        check("pair1_cap0", 64'(fr_cap[0]), 64'h01_3377EEFF);
        check("pair1_id0",  64'(fr_id[0]),  64'd0);
        check("pair1_cap1", 64'(fr_cap[1]), 64'h03_554466AA);
        check("pair1_id1",  64'(fr_id[1]),  64'd1);
        check("pair1_done1", 64'(fr_done[1]), 64'd1);

        // Single frame from requester 0
        req0_addr = 8'h02; req0_data = 32'hAABBCCDD; req0_valid = 1'b1;
        wait_ready(1'b0, "single_rdy0");
        req0_valid = 1'b0;
        wait_frames(3, "single_frames");
        check("single_cap",   64'(fr_cap[2]),   64'h02_AABBCCDD);
        check("single_len",   64'(fr_len[2]),   64'd328);
        check("single_edges", 64'(fr_edges[2]), 64'd40);
        check("single_done",  64'(fr_done[2]),  64'd1);
        check("single_id",    64'(fr_id[2]),    64'd0);
        check("single_busy",  64'(busy),        64'd1);

        // Second simultaneous pair, requester 0 granted last: requester 1 first
        snap = n_rdy0;
        req0_addr = 8'h11; req0_data = 32'h00000011; req0_valid = 1'b1;
        req1_addr = 8'h22; req1_data = 32'h22222222; req1_valid = 1'b1;
        wait_ready(1'b1, "pair2_rdy1");
        check("pair2_no_rdy0", 64'(n_rdy0 - snap), 64'd0);
        req1_valid = 1'b0;
        wait_ready(1'b0, "pair2_rdy0");
        req0_valid = 1'b0;
        wait_frames(5, "pair2_frames");
        check("pair2_id3",  64'(fr_id[3]),  64'd1);
        check("pair2_cap3", 64'(fr_cap[3]), 64'h22_22222222);
        check("pair2_id4",  64'(fr_id[4]),  64'd0);
        check("pair2_cap4", 64'(fr_cap[4]), 64'h11_00000011);

        // Back-to-back: requester 1 valid for three frames
        snap = n_rdy1;
        req1_addr = 8'h7E; req1_data = 32'hDEADBEEF; req1_valid = 1'b1;
        k = 0;
        while ((n_rdy1 - snap) < 3 && k < 1500) begin
            tick();
            k++;
        end
        req1_valid = 1'b0;
        wait_frames(8, "b2b_frames");
        check("b2b_ready_cnt", 64'(n_rdy1 - snap), 64'd3);
        for (int i = 5; i < 8; i++) begin
            check("b2b_edges", 64'(fr_edges[i]), 64'd40);
            check("b2b_cap",   64'(fr_cap[i]),   64'h7E_DEADBEEF);
        end
        check("b2b_gap6", 64'(fr_gap[6]), 64'd21);
        check("b2b_gap7", 64'(fr_gap[7]), 64'd21);

        // Reset in the middle of a frame
        req0_addr = 8'h44; req0_data = 32'h01234567; req0_valid = 1'b1;
        wait_ready(1'b0, "mid_rdy0");
        req0_valid = 1'b0;
        wait_edges(17, "mid_edges");
        snap = n_done;
        check("mid_clk_high", 64'(SPI_Clk), 64'd1);
        resetn = 1'b0;
        #1;
        check("mid_cs",   64'(SPI_CS),   64'd1);
        check("mid_clk",  64'(SPI_Clk),  64'd0);
        check("mid_mosi", 64'(SPI_MOSI), 64'd0);
        check("mid_busy", 64'(busy),     64'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("mid_frames",   64'(n_frames),    64'd9);
        check("mid_no_done",  64'(fr_done[8]),  64'd0);
        check("mid_part_edg", 64'(fr_edges[8]), 64'd17);
        req1_addr = 8'h5A; req1_data = 32'h12345678; req1_valid = 1'b1;
        wait_ready(1'b1, "post_rdy1");
        req1_valid = 1'b0;
        wait_frames(10, "post_frames");
        check("post_cap",   64'(fr_cap[9]),     64'h5A_12345678);
        check("post_len",   64'(fr_len[9]),     64'd328);
        check("post_edges", 64'(fr_edges[9]),   64'd40);
        check("post_ndone", 64'(n_done - snap), 64'd1);
        check("post_err",   64'(fr_err[9]),     64'd0);

        // Parameter sweep instance
        d2_req0_addr = 8'hC3; d2_req0_data = 32'h0F1E2D3C; d2_req0_valid = 1'b1;
        k = 0;
        while (!d2_req0_ready && k < 100) begin
            tick();
            k++;
        end
        check("sweep_rdy0", 64'(d2_req0_ready), 64'd1);
        d2_req0_valid = 1'b0;
        k = 0;
        while (n2 < 1 && k < 1000) begin
            tick();
            k++;
        end
        check("sweep_frames", 64'(n2),     64'd1);
        check("sweep_len",    64'(len2),   64'd165);
        check("sweep_edges",  64'(edges2), 64'd40);
        check("sweep_cap",    64'(cap2),   64'hC3_0F1E2D3C);
        check("sweep_done",   64'(fdone2), 64'd1);
        check("sweep_id",     64'(fid2),   64'd0);

`ifdef ASKA_SPI_SCHED_ABORT_EN
        // Abort during the fourth byte
        req0_addr = 8'h03; req0_data = 32'h554466AA; req0_valid = 1'b1;
        wait_ready(1'b0, "abort_rdy0");
        req0_valid = 1'b0;
        wait_edges(26, "abort_edge26");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_frames(11, "abort_frames");
        check("abort_edges", 64'(fr_edges[10]),      64'd32);
        check("abort_cap",   64'(fr_cap[10][31:0]),  64'h03554466);
        check("abort_len",   64'(fr_len[10]),        64'd264);
        check("abort_done",  64'(fr_done[10]),       64'd1);
        check("abort_err",   64'(fr_err[10]),        64'd1);
`endif

        repeat (30) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
